bram_sdp_ctrl: RTL and testbench
================================

Name: bram_sdp_ctrl

Overview:
- Parametrised simple-dual-port block RAM: one write port and one read port, both on a single clock.
- Adds configurable read latency, selectable read-during-write semantics and out-of-range address handling.
- A hardware clear engine zeroes the array after reset or on request.
- Successor to the single-port 10-bit/64-entry scratch RAM. Used as the CPU data/register store and as the testbench-visible memory model.

Parameters:
- DATA_W, 10, data word width in bits (1..64).
- ADDR_W, 6, address width in bits.
- DEPTH, 64, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W (non-power-of-two allowed).
- READ_LAT, 1, read latency in cycles; legal values 1 or 2. Value 2 adds an output register.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (write-first bypass).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous reset, active-low (0 = reset asserted).
- i_clr  in  1  request a full-array clear; sampled only in READY.
- o_busy  out  1  high while the clear engine runs; all port accesses are ignored while high.
- i_we  in  1  write enable.
- i_waddr  in  ADDR_W  write address.
- i_wdata  in  DATA_W  write data.
- i_re  in  1  read enable.
- i_raddr  in  ADDR_W  read address.
- o_rdata  out  DATA_W  read data.
- o_rvalid  out  1  one-cycle pulse qualifying o_rdata.

Behaviour:
- Reset (rst=0, asynchronous):
  - o_rdata=0, o_rvalid=0, all read-pipeline valid bits=0.
  - FSM forced to CLEAR with clear counter=0; o_busy=1 combinationally from state.
  - Array contents are not reset asynchronously; they are zeroed by the clear engine.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 to address cnt, then cnt++. After cnt==DEPTH-1 is written, go to READY. Exactly DEPTH cycles after reset release.
  - CLEAR: i_we, i_re and i_clr are ignored (a second request does not restart the count).
  - READY: i_clr=1 moves to CLEAR next cycle with cnt=0; o_busy rises that edge.
  - READY: a write or read in the same cycle as i_clr is still performed.
  - Reset asserted mid-clear restarts the clear from address 0.
- Write (READY, i_we=1):
  - Address < DEPTH: mem[i_waddr] <= i_wdata at posedge.
  - Address >= DEPTH: write silently dropped.
- Read (READY, i_re=1, sampled at edge T):
  - o_rdata and o_rvalid=1 appear after edge T+READ_LAT-1 and are visible in cycle T+READ_LAT.
  - o_rvalid is high for exactly one cycle per accepted read. Back-to-back reads give one result per cycle.
  - Address >= DEPTH returns 0 with o_rvalid=1.
  - o_rdata holds its last value when no read completes.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns i_wdata.
  - Different addresses do not interact.
- Reads in flight when CLEAR is entered complete normally with data captured at sample time.
- No reads are accepted during CLEAR, so o_rvalid is 0 from cycle READ_LAT after entry until READY.

Decomposition:
- Shared package bram_pkg:
  - state enum {CLEAR, READY};
  - localparams RDW_OLD=0, RDW_NEW=1;
  - a function checking the DEPTH/ADDR_W/READ_LAT legality, used by an elaboration-time assertion.
- One natural sub-module: bram_clr_ctrl. It holds the FSM plus the clear counter and drives the internal write mux and o_busy.
- Array, bypass and read pipeline stay in bram_sdp_ctrl.

Test Plan:
- Reset/clear: release rst and idle 64 cycles -> o_busy stays 1 for exactly 64 cycles. Reads of addresses 0, 31 and 63 then return 0x000 with o_rvalid one cycle after i_re.
- Write/read, READ_LAT=1 then 2:
  - Write 0x3A5 to addr 5, read addr 5 next cycle -> o_rdata=0x3A5 after 1 (resp. 2) cycles.
  - Back-to-back reads of addrs 5, 6 -> two consecutive o_rvalid pulses.
- Read-during-write: mem[9]=0x111, same-cycle write 0x222 and read addr 9 -> RDW_MODE=0 returns 0x111, RDW_MODE=1 returns 0x222. Subsequent read returns 0x222 in both modes.
- Out of range, DEPTH=40, ADDR_W=6:
  - Write 0x155 to addr 45 -> dropped.
  - Read addr 45 -> 0x000 with valid.
  - Read addr 39 -> unaffected.
- Clear request: fill addrs 0..63 with address value, pulse i_clr:
  - o_busy high 64 cycles, and i_we during busy to addr 3 is ignored.
  - Afterwards all reads return 0.
- Reset mid-clear: assert rst at clear cycle 20 for 2 cycles -> outputs 0 immediately, o_busy=1. Clear then takes a full 64 cycles from release.

Source files
------------

// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_pkg
// Description : Shared types and constants for the simple-dual-port BRAM
//               controller: FSM state encoding, read-during-write mode codes
//               and a parameter legality check used at elaboration time.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_pkg;

    // Clear engine state. CLEAR is the reset state.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Same-address read-during-write result selection.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // True when the parameter set describes a buildable memory.
    function automatic bit params_legal(
        input int data_w,
        input int addr_w,
        input int depth,
        input int read_lat,
        input int rdw_mode
    );
        return (data_w >= 1) && (data_w <= 64) &&
               (addr_w >= 1) && (addr_w <= 30) &&
               (depth >= 1) && (depth <= (1 << addr_w)) &&
               ((read_lat == 1) || (read_lat == 2)) &&
               ((rdw_mode == RDW_OLD) || (rdw_mode == RDW_NEW));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_clr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_clr_ctrl
// Description : Clear engine for bram_sdp_ctrl. Walks every word writing zero
//               after reset or on request, and otherwise forwards in-range
//               user writes to the array write port.
// Ports       : clk, rst (async, active-low)
//               i_clr            - clear request, honoured only in READY
//               i_we/i_waddr/i_wdata - user write request
//               o_busy           - clear engine running
//               o_mem_we/o_mem_addr/o_mem_wdata - array write port
// Revision    : 1.0 - initial release
// ============================================================================
module bram_clr_ctrl
    import bram_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   c_depth     = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              w_wr_in_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    // Requests arriving here are ignored; the walk never restarts.
                    if (r_cnt == c_last_addr) begin
                        r_state <= READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                READY: begin
                    if (i_clr) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_wr_in_range = ({1'b0, i_waddr} < c_depth);
    assign o_busy        = (r_state == CLEAR);

    // The engine owns the write port while busy; user writes beyond DEPTH vanish.
    assign o_mem_we    = o_busy ? 1'b1  : (i_we && w_wr_in_range);
    assign o_mem_addr  = o_busy ? r_cnt : i_waddr;
    assign o_mem_wdata = o_busy ? '0    : i_wdata;

endmodule
`default_nettype wire

// File: rtl/bram_sdp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_sdp_ctrl
// Description : Parametrised simple-dual-port block RAM, single clock, with
//               1 or 2 cycle read latency, selectable read-during-write
//               result, out-of-range address handling and a clear engine.
// Ports       : clk, rst (async, active-low)
//               i_clr, o_busy          - clear request / engine running
//               i_we, i_waddr, i_wdata - write port
//               i_re, i_raddr          - read request
//               o_rdata, o_rvalid      - read result and one-cycle qualifier
// Revision    : 1.0 - initial release
// ============================================================================
module bram_sdp_ctrl
    import bram_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int ADDR_W   = 6,
    parameter int DEPTH    = 64,
    parameter int READ_LAT = 1,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    output logic              o_busy,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

    generate
        if (!params_legal(DATA_W, ADDR_W, DEPTH, READ_LAT, RDW_MODE)) begin : g_param_check
            $error("bram_sdp_ctrl: illegal DATA_W/ADDR_W/DEPTH/READ_LAT/RDW_MODE");
        end
    endgenerate

    logic              w_busy;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    bram_clr_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (i_clr),
        .i_we        (i_we),
        .i_waddr     (i_waddr),
        .i_wdata     (i_wdata),
        .o_busy      (w_busy),
        .o_mem_we    (w_mem_we),
        .o_mem_addr  (w_mem_addr),
        .o_mem_wdata (w_mem_wdata)
    );

    assign o_busy = w_busy;

    // Storage carries no reset; the clear engine zeroes it.
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    logic              w_rd_acc;
    logic              w_rd_in_range;
    logic              w_bypass;
    logic [DATA_W-1:0] w_rd_word;

    assign w_rd_acc      = i_re && !w_busy;
    assign w_rd_in_range = ({1'b0, i_raddr} < c_depth);
    // Write-first: a same-cycle write to the read address wins. An
    // out-of-range write can only match an out-of-range read, which reads 0.
    assign w_bypass      = (RDW_MODE == RDW_NEW) && i_we && (i_waddr == i_raddr);

    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = w_bypass ? i_wdata : r_mem[i_raddr];
        end
    end

    // First read stage: data captured at sample time, held when idle.
    logic [DATA_W-1:0] r_rdata_s1;
    logic              r_rvalid_s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata_s1  <= '0;
            r_rvalid_s1 <= 1'b0;
        end else begin
            r_rvalid_s1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_rdata_s1 <= w_rd_word;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_rdata_s2;
            logic              r_rvalid_s2;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rdata_s2  <= '0;
                    r_rvalid_s2 <= 1'b0;
                end else begin
                    r_rvalid_s2 <= r_rvalid_s1;
                    if (r_rvalid_s1) begin
                        r_rdata_s2 <= r_rdata_s1;
                    end
                end
            end

            assign o_rdata  = r_rdata_s2;
            assign o_rvalid = r_rvalid_s2;
        end else begin : g_lat1
            assign o_rdata  = r_rdata_s1;
            assign o_rvalid = r_rvalid_s1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bram_sdp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_sdp_ctrl
// Description : Self-checking bench for bram_sdp_ctrl. Two instances share
//               one stimulus stream: A uses the default configuration
//               (64 words, latency 1, old-data RDW), B uses 40 words,
//               latency 2 and new-data RDW. Expected read data are queued
//               when a read is driven and retired when the result is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_sdp_ctrl;

    localparam int DW      = 10;
    localparam int AW      = 6;
    localparam int DEPTH_A = 64;
    localparam int DEPTH_B = 40;
    localparam int LAT_A   = 1;
    localparam int LAT_B   = 2;
    localparam int NVEC    = 22;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          i_clr   = 1'b0;
    logic          i_we    = 1'b0;
    logic          i_re    = 1'b0;
    logic [AW-1:0] i_waddr = '0;
    logic [AW-1:0] i_raddr = '0;
    logic [DW-1:0] i_wdata = '0;

    logic          busy_a, busy_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;

    always #5 clk = ~clk;

    bram_sdp_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_A), .READ_LAT(LAT_A), .RDW_MODE(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .i_clr(i_clr), .o_busy(busy_a),
        .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_re(i_re), .i_raddr(i_raddr), .o_rdata(rdata_a), .o_rvalid(rvalid_a)
    );

    bram_sdp_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_B), .READ_LAT(LAT_B), .RDW_MODE(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .i_clr(i_clr), .o_busy(busy_b),
        .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_re(i_re), .i_raddr(i_raddr), .o_rdata(rdata_b), .o_rvalid(rvalid_b)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    bit   mbusy_a  = 1'b1;
    bit   mbusy_b  = 1'b1;
    int   mcnt_a   = 0;
    int   mcnt_b   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input string tag, input logic v, input logic [DW-1:0] d, input bit is_b);
        exp_t e;
        bit   have;
        have = is_b ? (q_b.size() > 0 && q_b[0].due == cyc)
                    : (q_a.size() > 0 && q_a[0].due == cyc);
        e = '{'0, 0};
        if (have) e = is_b ? q_b.pop_front() : q_a.pop_front();
        if (v || have) begin
            check({tag, "_rvalid"}, 32'(v), 32'(have));
            if (v && have) check({tag, "_rdata"}, 32'(d), 32'(e.data));
        end
    endtask

    // Busy model and scoreboard retirement, just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            mbusy_a = 1'b1; mcnt_a = 0;
            mbusy_b = 1'b1; mcnt_b = 0;
            q_a.delete();
            q_b.delete();
        end else begin
            if (mbusy_a) begin
                mcnt_a++;
                if (mcnt_a == DEPTH_A) mbusy_a = 1'b0;
            end else if (i_clr) begin
                mbusy_a = 1'b1; mcnt_a = 0;
            end
            if (mbusy_b) begin
                mcnt_b++;
                if (mcnt_b == DEPTH_B) mbusy_b = 1'b0;
            end else if (i_clr) begin
                mbusy_b = 1'b1; mcnt_b = 0;
            end
            check("busy_a", 32'(busy_a), 32'(mbusy_a));
            check("busy_b", 32'(busy_b), 32'(mbusy_b));
            score("a", rvalid_a, rdata_a, 1'b0);
            score("b", rvalid_b, rdata_b, 1'b1);
        end
    end

    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra, input logic clr,
                        input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        @(negedge clk);
        i_we    = we;
        i_waddr = wa;
        i_wdata = wd;
        i_re    = re;
        i_raddr = ra;
        i_clr   = clr;
        if (re && !mbusy_a) q_a.push_back('{ea, cyc + LAT_A});
        if (re && !mbusy_b) q_b.push_back('{eb, cyc + LAT_B});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt [NVEC];
    int   nb_a, nb_b;

    initial begin
        //            we    wa     wd      re    ra     ea      eb
        vt[0]  = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd0,  10'h000, 10'h000};
        vt[1]  = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd31, 10'h000, 10'h000};
        vt[2]  = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd63, 10'h000, 10'h000};
        vt[3]  = '{1'b1, 6'd5,  10'h3A5, 1'b0, 6'd0,  10'h000, 10'h000};
        vt[4]  = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd5,  10'h3A5, 10'h3A5};
        vt[5]  = '{1'b1, 6'd6,  10'h0C3, 1'b0, 6'd0,  10'h000, 10'h000};
        vt[6]  = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd5,  10'h3A5, 10'h3A5};
        vt[7]  = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd6,  10'h0C3, 10'h0C3};
        vt[8]  = '{1'b1, 6'd9,  10'h111, 1'b0, 6'd0,  10'h000, 10'h000};
        vt[9]  = '{1'b1, 6'd9,  10'h222, 1'b1, 6'd9,  10'h111, 10'h222};
        vt[10] = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd9,  10'h222, 10'h222};
        vt[11] = '{1'b1, 6'd45, 10'h155, 1'b0, 6'd0,  10'h000, 10'h000};
        vt[12] = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd45, 10'h155, 10'h000};
        vt[13] = '{1'b1, 6'd39, 10'h2AA, 1'b0, 6'd0,  10'h000, 10'h000};
        vt[14] = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd39, 10'h2AA, 10'h2AA};
        vt[15] = '{1'b1, 6'd45, 10'h0F0, 1'b1, 6'd45, 10'h155, 10'h000};
        vt[16] = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd45, 10'h0F0, 10'h000};
        vt[17] = '{1'b1, 6'd10, 10'h001, 1'b1, 6'd11, 10'h000, 10'h000};
        vt[18] = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd10, 10'h001, 10'h001};
        vt[19] = '{1'b0, 6'd0,  10'h000, 1'b0, 6'd0,  10'h000, 10'h000};
        vt[20] = '{1'b1, 6'd63, 10'h3FF, 1'b1, 6'd0,  10'h000, 10'h000};
        vt[21] = '{1'b0, 6'd0,  10'h000, 1'b1, 6'd63, 10'h3FF, 10'h000};

        // Reset and power-on clear.
        repeat (3) @(negedge clk);
        #1;
        check("reset_rdata_a", 32'(rdata_a), 32'h0);
        check("reset_rvalid_a", 32'(rvalid_a), 32'h0);
        check("reset_busy_a", 32'(busy_a), 32'h1);
        check("reset_rdata_b", 32'(rdata_b), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(64);

        // Vector table: writes, reads, read-during-write, out-of-range.
        for (int i = 0; i < NVEC; i++) begin
            step(vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra, 1'b0, vt[i].ea, vt[i].eb);
        end
        idle(3);

        // Fill with address value, read back, then request a clear.
        for (int i = 0; i < 64; i++) step(1'b1, 6'(i), 10'(i), 1'b0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 64; i++)
            step(1'b0, '0, '0, 1'b1, 6'(i), 1'b0, 10'(i), (i < DEPTH_B) ? 10'(i) : 10'd0);
        // Read and write alongside the request are still carried out.
        step(1'b1, 6'd2, 10'h2F0, 1'b1, 6'd7, 1'b1, 10'd7, 10'd7);
        idle(9);
        step(1'b1, 6'd3, 10'h155, 1'b1, 6'd3, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, '0, '0);
        idle(60);
        for (int i = 0; i < 64; i++) step(1'b0, '0, '0, 1'b1, 6'(i), 1'b0, 10'd0, 10'd0);
        idle(3);

        // Reset in the middle of a clear.
        step(1'b1, 6'd4, 10'h123, 1'b0, '0, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 6'd4, 1'b0, 10'h123, 10'h123);
        idle(3);
        check("hold_rdata_a", 32'(rdata_a), 32'h123);
        check("hold_rdata_b", 32'(rdata_b), 32'h123);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, '0, '0);
        idle(20);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_rdata_a", 32'(rdata_a), 32'h0);
        check("midrst_rdata_b", 32'(rdata_b), 32'h0);
        check("midrst_rvalid_b", 32'(rvalid_b), 32'h0);
        check("midrst_busy_a", 32'(busy_a), 32'h1);
        check("midrst_busy_b", 32'(busy_b), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
        nb_a = 0;
        nb_b = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy_a) nb_a++;
            if (busy_b) nb_b++;
            @(negedge clk);
        end
        check("clear_len_a", 32'(nb_a), 32'd64);
        check("clear_len_b", 32'(nb_b), 32'd40);
        step(1'b0, '0, '0, 1'b1, 6'd4, 1'b0, 10'd0, 10'd0);
        step(1'b0, '0, '0, 1'b1, 6'd0, 1'b0, 10'd0, 10'd0);
        idle(4);

        check("sb_empty_a", 32'(q_a.size()), 32'd0);
        check("sb_empty_b", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
